// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose rd feeds the ID instruction causes one bubble into EX while IF/ID is frozen.
module id_ex_stage #(
    parameter int XLEN = 64,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [2:0]      id_funct3,
    input  logic [6:0]      id_funct7,
    input  logic            id_ALU_src,
    input  logic            id_Mem_to_Reg,
    input  logic            id_Reg_Write,
    input  logic            id_Mem_Read,
    input  logic            id_Mem_Write,
    input  logic            id_Branch_en,
    input  logic [XLEN-1:0] id_ValA,
    input  logic [XLEN-1:0] id_ValB,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic            flush,
    input  logic            ex_hold,
    output logic            stall_id,
    output logic            ex_valid,
    output logic            ex_ALU_src,
    output logic            ex_Mem_to_Reg,
    output logic            ex_Reg_Write,
    output logic            ex_Mem_Read,
    output logic            ex_Mem_Write,
    output logic            ex_Branch_en,
    output logic [XLEN-1:0] ex_ValA,
    output logic [XLEN-1:0] ex_ValB,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic [REGW-1:0] ex_rs1,
    output logic [REGW-1:0] ex_rs2,
    output logic [REGW-1:0] ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7
);

    typedef struct packed {
        logic            valid;
        logic            alu_src;
        logic            mem_to_reg;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch_en;
        logic [XLEN-1:0] val_a;
        logic [XLEN-1:0] val_b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
    } ex_fields_t;

    ex_fields_t ex_q;
    ex_fields_t id_fields;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       hazard;

    // R-type, stores and branches read both sources; OP-IMM, loads and JALR read only rs1.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign hazard = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                    ((uses_rs1 & (ex_q.rd == id_rs1)) | (uses_rs2 & (ex_q.rd == id_rs2)));

    assign stall_id = hazard | ex_hold;

    always_comb begin
        id_fields            = '0;
        id_fields.valid      = id_valid;
        id_fields.alu_src    = id_ALU_src;
        id_fields.mem_to_reg = id_Mem_to_Reg;
        id_fields.reg_write  = id_Reg_Write;
        id_fields.mem_read   = id_Mem_Read;
        id_fields.mem_write  = id_Mem_Write;
        id_fields.branch_en  = id_Branch_en;
        id_fields.val_a      = id_ValA;
        id_fields.val_b      = id_ValB;
        id_fields.imm        = id_imm;
        id_fields.pc         = id_pc;
        id_fields.rs1        = id_rs1;
        id_fields.rs2        = id_rs2;
        id_fields.rd         = id_rd;
        id_fields.funct3     = id_funct3;
        id_fields.funct7     = id_funct7;
    end

    // Flush beats hold, hold beats the hazard bubble; an empty ID slot also becomes a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            ex_q <= '0;
        end else if (!ex_hold) begin
            if (hazard || !id_valid) begin
                ex_q <= '0;
            end else begin
                ex_q <= id_fields;
            end
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_ALU_src    = ex_q.alu_src;
    assign ex_Mem_to_Reg = ex_q.mem_to_reg;
    assign ex_Reg_Write  = ex_q.reg_write;
    assign ex_Mem_Read   = ex_q.mem_read;
    assign ex_Mem_Write  = ex_q.mem_write;
    assign ex_Branch_en  = ex_q.branch_en;
    assign ex_ValA       = ex_q.val_a;
    assign ex_ValB       = ex_q.val_b;
    assign ex_imm        = ex_q.imm;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_funct3     = ex_q.funct3;
    assign ex_funct7     = ex_q.funct7;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the EX-side register and the stall rule.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        id_ALU_src, id_Mem_to_Reg, id_Reg_Write, id_Mem_Read, id_Mem_Write, id_Branch_en;
    logic [63:0] id_ValA, id_ValB, id_imm, id_pc;
    logic        flush, ex_hold;
    logic        stall_id, ex_valid;
    logic        ex_ALU_src, ex_Mem_to_Reg, ex_Reg_Write, ex_Mem_Read, ex_Mem_Write, ex_Branch_en;
    logic [63:0] ex_ValA, ex_ValB, ex_imm, ex_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;

    int tests = 0;
    int failures = 0;
    bit lastStall = 1'b0;

    // Expected EX contents; ctrl order is {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch_en}.
    typedef struct packed {
        logic        valid;
        logic [5:0]  ctrl;
        logic [63:0] a, b, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } exp_t;
    exp_t m = '0;

    localparam int ADD = 0, ADDI = 1, LD = 2, SD = 3, BEQ = 4, JALR = 5, LUI = 6;

    id_ex_stage #(.XLEN(64), .REGW(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .id_ALU_src(id_ALU_src), .id_Mem_to_Reg(id_Mem_to_Reg), .id_Reg_Write(id_Reg_Write),
        .id_Mem_Read(id_Mem_Read), .id_Mem_Write(id_Mem_Write), .id_Branch_en(id_Branch_en),
        .id_ValA(id_ValA), .id_ValB(id_ValB), .id_imm(id_imm), .id_pc(id_pc),
        .flush(flush), .ex_hold(ex_hold), .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_ALU_src(ex_ALU_src), .ex_Mem_to_Reg(ex_Mem_to_Reg), .ex_Reg_Write(ex_Reg_Write),
        .ex_Mem_Read(ex_Mem_Read), .ex_Mem_Write(ex_Mem_Write), .ex_Branch_en(ex_Branch_en),
        .ex_ValA(ex_ValA), .ex_ValB(ex_ValB), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic bit readsRs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    endfunction

    function automatic bit readsRs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit modelHazard();
        return id_valid && m.valid && m.ctrl[2] && (m.rd != 0) &&
               ((readsRs1(id_opcode) && m.rd == id_rs1) || (readsRs2(id_opcode) && m.rd == id_rs2));
    endfunction

    function automatic void modelEdge();
        if (!rst_n || flush) m = '0;
        else if (ex_hold) m = m;
        else if (!id_valid || modelHazard()) m = '0;
        else begin
            m.valid = 1'b1;
            m.ctrl  = {id_ALU_src, id_Mem_to_Reg, id_Reg_Write, id_Mem_Read, id_Mem_Write, id_Branch_en};
            m.a = id_ValA; m.b = id_ValB; m.imm = id_imm; m.pc = id_pc;
            m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd; m.f3 = id_funct3; m.f7 = id_funct7;
        end
    endfunction

    // Drives one decoded instruction into the ID slot with random data fields.
    task automatic applyStimulus(input int kind, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        logic [5:0] c;
        case (kind)
            ADD:  begin id_opcode = 7'b0110011; c = 6'b001000; end
            ADDI: begin id_opcode = 7'b0010011; c = 6'b101000; end
            LD:   begin id_opcode = 7'b0000011; c = 6'b111100; end
            SD:   begin id_opcode = 7'b0100011; c = 6'b100010; end
            BEQ:  begin id_opcode = 7'b1100011; c = 6'b000001; end
            JALR: begin id_opcode = 7'b1100111; c = 6'b101000; end
            default: begin id_opcode = 7'b0110111; c = 6'b101000; end
        endcase
        {id_ALU_src, id_Mem_to_Reg, id_Reg_Write, id_Mem_Read, id_Mem_Write, id_Branch_en} = c;
        id_valid = 1'b1;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_funct3 = 3'($urandom); id_funct7 = 7'($urandom);
        id_ValA = {$urandom, $urandom}; id_ValB = {$urandom, $urandom};
        id_imm = {$urandom, $urandom}; id_pc = {$urandom, $urandom};
    endtask

    task automatic checkOutput();
        checkVal("ex_valid", 64'(ex_valid), 64'(m.valid));
        checkVal("ex_ctrl", 64'({ex_ALU_src, ex_Mem_to_Reg, ex_Reg_Write, ex_Mem_Read, ex_Mem_Write, ex_Branch_en}), 64'(m.ctrl));
        checkVal("ex_ValA", ex_ValA, m.a);
        checkVal("ex_ValB", ex_ValB, m.b);
        checkVal("ex_imm", ex_imm, m.imm);
        checkVal("ex_pc", ex_pc, m.pc);
        checkVal("ex_idx", 64'({ex_rs1, ex_rs2, ex_rd}), 64'({m.rs1, m.rs2, m.rd}));
        checkVal("ex_funct", 64'({ex_funct3, ex_funct7}), 64'({m.f3, m.f7}));
    endtask

    // One clock: stall checked mid-cycle, model advanced at the edge, registers checked just after.
    task automatic clockEdge(input bit chkStall);
        @(negedge clk);
        lastStall = modelHazard() || ex_hold;
        if (chkStall) checkVal("stall_id", 64'(stall_id), 64'(lastStall));
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic expectStall(input bit v, input string tag);
        #1;
        checkVal(tag, 64'(stall_id), 64'(v));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b0;
        applyStimulus(LD, 5'd1, 5'd2, 5'd3);
        #1;
        @(posedge clk); modelEdge(); #1;
        applyStimulus(ADD, 5'($urandom), 5'($urandom), 5'($urandom));
        clockEdge(1'b1);
        checkVal("reset_stall", 64'(stall_id), 64'd0);

        rst_n = 1'b1;
        applyStimulus(ADD, 5'd1, 5'd2, 5'd3);
        id_ValA = 64'h5; id_ValB = 64'h7;
        clockEdge(1'b1);
        checkVal("add_regwrite", 64'(ex_Reg_Write), 64'd1);
        checkVal("add_rd", 64'(ex_rd), 64'd3);
        checkVal("add_vala", ex_ValA, 64'h5);
        checkVal("add_valb", ex_ValB, 64'h7);
        checkVal("add_valid", 64'(ex_valid), 64'd1);

        // Load-use on rs1: one bubble, then the ADD goes through.
        applyStimulus(LD, 5'd1, 5'd0, 5'd8); clockEdge(1'b1);
        applyStimulus(ADD, 5'd8, 5'd2, 5'd9); expectStall(1'b1, "lu_stall");
        clockEdge(1'b1);
        checkVal("lu_bubble", 64'(ex_valid), 64'd0);
        expectStall(1'b0, "lu_resolved");
        clockEdge(1'b1);
        checkVal("lu_capture_rs1", 64'(ex_rs1), 64'd8);

        applyStimulus(LD, 5'd1, 5'd0, 5'd8); clockEdge(1'b1);
        applyStimulus(LD, 5'd9, 5'd0, 5'd4); expectStall(1'b0, "ld_ld_indep");
        clockEdge(1'b1);
        applyStimulus(LD, 5'd1, 5'd0, 5'd0); clockEdge(1'b1);
        applyStimulus(ADD, 5'd0, 5'd0, 5'd5); expectStall(1'b0, "ld_x0");
        clockEdge(1'b1);
        applyStimulus(LD, 5'd1, 5'd0, 5'd8); clockEdge(1'b1);
        applyStimulus(LD, 5'd7, 5'd8, 5'd4); expectStall(1'b0, "ld_rs2_unused");
        clockEdge(1'b1);

        // rs2 dependencies through store and branch.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(LD, 5'd1, 5'd0, 5'd10); clockEdge(1'b1);
            applyStimulus(k == 0 ? SD : BEQ, 5'd3, 5'd10, 5'd0);
            expectStall(1'b1, "rs2_stall");
            clockEdge(1'b1);
            checkVal("rs2_bubble", 64'(ex_valid), 64'd0);
            clockEdge(1'b1);
            checkVal("rs2_capture", 64'({ex_Mem_Write, ex_Branch_en}), k == 0 ? 64'b10 : 64'b01);
        end

        // Hold freezes EX; flush wins over hold and over a hazard.
        applyStimulus(ADD, 5'd4, 5'd5, 5'd9); clockEdge(1'b1);
        ex_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(ADDI, 5'($urandom), 5'($urandom), 5'($urandom));
            expectStall(1'b1, "hold_stall");
            clockEdge(1'b1);
            checkVal("hold_rd", 64'(ex_rd), 64'd9);
        end
        flush = 1'b1; clockEdge(1'b1);
        checkVal("flush_hold_bubble", 64'(ex_valid), 64'd0);
        flush = 1'b0; ex_hold = 1'b0;
        applyStimulus(LD, 5'd1, 5'd0, 5'd8); clockEdge(1'b1);
        applyStimulus(ADD, 5'd8, 5'd2, 5'd6); flush = 1'b1; clockEdge(1'b1);
        checkVal("flush_hazard_bubble", 64'(ex_valid), 64'd0);
        flush = 1'b0; clockEdge(1'b1);
        checkVal("after_flush_rs1", 64'(ex_rs1), 64'd8);

        // Reset while a load-use hazard is pending.
        applyStimulus(LD, 5'd1, 5'd0, 5'd8); clockEdge(1'b1);
        applyStimulus(ADD, 5'd8, 5'd2, 5'd6); expectStall(1'b1, "pre_reset_stall");
        rst_n = 1'b0; clockEdge(1'b1);
        checkVal("reset_mid_memread", 64'(ex_Mem_Read), 64'd0);
        checkVal("reset_mid_stall", 64'(stall_id), 64'd0);
        rst_n = 1'b1;

        // Random traffic; the ID instruction is retained while stall_id is expected high.
        for (int i = 0; i < 400; i++) begin
            if (!lastStall)
                applyStimulus($urandom_range(0, 6), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                              5'($urandom_range(0, 5)));
            id_valid = ($urandom_range(0, 99) < 90);
            ex_hold  = ($urandom_range(0, 99) < 15);
            flush    = ($urandom_range(0, 99) < 10);
            rst_n    = !($urandom_range(0, 99) < 2);
            clockEdge(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
